// File: rtl/i2c_register_bank.sv
// Register bank behind i2c_peripheral: read-only ID, sticky W1C status, and RW control registers.
// Serves the peripheral's read (valid/ack) and write (four-phase valid/ack) handshakes.
module i2c_register_bank #(
  parameter int         NUM_REGS      = 16,
  parameter logic [7:0] DEVICE_ID     = 8'hA5,
  parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
  input  logic                        i_sys_clk,
  input  logic                        i_rst_n,
  input  logic [7:0]                  i_register_address,
  input  logic                        i_read_enable,
  output logic [7:0]                  o_register_data,
  output logic                        o_read_valid,
  input  logic                        i_read_ack,
  input  logic [7:0]                  i_register_data,
  input  logic                        i_write_valid,
  output logic                        o_write_ack,
  input  logic [7:0]                  i_status_set,
  output logic [8*(NUM_REGS-2)-1:0]   o_ctrl_regs,
  output logic                        o_ctrl_wr_strobe,
  output logic [7:0]                  o_ctrl_wr_index,
  output logic                        o_addr_err,
  output logic [1:0]                  o_dbg_state
);

  // Handshakes: a read request (i_read_enable) seen in IDLE yields o_read_valid
  // one clock later with snapshot data, held until i_read_ack. A write request
  // (i_write_valid) seen in IDLE is applied on that edge and acked; o_write_ack
  // stays high until i_write_valid drops. Writes win over simultaneous reads.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_VALID = 2'd1,
    ST_WR_ACK   = 2'd2
  } state_t;

  localparam int         NUM_CTRL = NUM_REGS - 2;
  localparam logic [8:0] LIMIT    = 9'(NUM_REGS);

  state_t     r_state;
  logic [7:0] r_status;
  logic [7:0] r_ctrl [NUM_CTRL];

  logic [8:0] w_addr9;
  logic       w_is_id;
  logic       w_is_status;
  logic       w_is_unmapped;
  logic       w_is_ctrl;
  logic       w_wr_fire;
  logic [7:0] w_w1c;
  logic [7:0] w_ctrl_rd;
  logic [7:0] w_rd_data;

  // Nine-bit compare so NUM_REGS=256 leaves no unmapped space.
  assign w_addr9       = {1'b0, i_register_address};
  assign w_is_id       = (i_register_address == 8'h00);
  assign w_is_status   = (i_register_address == 8'h01);
  assign w_is_unmapped = (w_addr9 >= LIMIT);
  assign w_is_ctrl     = !w_is_id && !w_is_status && !w_is_unmapped;
  assign w_wr_fire     = (r_state == ST_IDLE) && i_write_valid;
  assign w_w1c         = (w_wr_fire && w_is_status) ? i_register_data : 8'h00;
  assign o_dbg_state   = r_state;

  always_comb begin
    w_ctrl_rd = 8'h00;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (w_addr9 == 9'(i + 2)) w_ctrl_rd = r_ctrl[i];
    end
  end

  always_comb begin
    if (w_is_id)            w_rd_data = DEVICE_ID;
    else if (w_is_status)   w_rd_data = r_status;
    else if (w_is_unmapped) w_rd_data = UNMAPPED_DATA;
    else                    w_rd_data = w_ctrl_rd;
  end

  // Set is applied after the clear so a same-cycle event keeps its bit.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_status <= 8'h00;
    else          r_status <= (r_status & ~w_w1c) | i_status_set;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CTRL; i++) r_ctrl[i] <= 8'h00;
    end else if (w_wr_fire && w_is_ctrl) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (w_addr9 == 9'(i + 2)) r_ctrl[i] <= i_register_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_flat
    assign o_ctrl_regs[8*g +: 8] = r_ctrl[g];
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= ST_IDLE;
      o_register_data  <= 8'h00;
      o_read_valid     <= 1'b0;
      o_write_ack      <= 1'b0;
      o_ctrl_wr_strobe <= 1'b0;
      o_ctrl_wr_index  <= 8'h00;
      o_addr_err       <= 1'b0;
    end else begin
      o_ctrl_wr_strobe <= 1'b0;
      o_addr_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_write_valid) begin
            o_write_ack <= 1'b1;
            r_state     <= ST_WR_ACK;
            if (w_is_ctrl) begin
              o_ctrl_wr_strobe <= 1'b1;
              o_ctrl_wr_index  <= i_register_address;
            end
            if (w_is_id || w_is_unmapped) o_addr_err <= 1'b1;
          end else if (i_read_enable) begin
            o_register_data <= w_rd_data;
            o_read_valid    <= 1'b1;
            o_addr_err      <= w_is_unmapped;
            r_state         <= ST_RD_VALID;
          end
        end
        ST_RD_VALID: begin
          if (i_read_ack) begin
            o_read_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        ST_WR_ACK: begin
          if (!i_write_valid) begin
            o_write_ack <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          o_read_valid <= 1'b0;
          o_write_ack  <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_register_bank.sv
// Directed bench for i2c_register_bank: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_i2c_register_bank;
  localparam int NUM_REGS = 16;
  localparam int CW       = 8 * (NUM_REGS - 2);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    addr = 8'h00;
  logic          re = 1'b0;
  logic [7:0]    rdata;
  logic          rvalid;
  logic          rack = 1'b0;
  logic [7:0]    wdata = 8'h00;
  logic          wv = 1'b0;
  logic          wack;
  logic [7:0]    status_set = 8'h00;
  logic [CW-1:0] ctrl_regs;
  logic          strobe;
  logic [7:0]    wr_index;
  logic          addr_err;
  logic [1:0]    dbg_state;

  i2c_register_bank #(.NUM_REGS(NUM_REGS), .DEVICE_ID(8'hA5), .UNMAPPED_DATA(8'hFF)) dut (
    .i_sys_clk(clk),
    .i_rst_n(rst_n),
    .i_register_address(addr),
    .i_read_enable(re),
    .o_register_data(rdata),
    .o_read_valid(rvalid),
    .i_read_ack(rack),
    .i_register_data(wdata),
    .i_write_valid(wv),
    .o_write_ack(wack),
    .i_status_set(status_set),
    .o_ctrl_regs(ctrl_regs),
    .o_ctrl_wr_strobe(strobe),
    .o_ctrl_wr_index(wr_index),
    .o_addr_err(addr_err),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: register contents plus "read in flight" / "write in flight" flags
  logic       m_rd = 1'b0, m_wr = 1'b0, m_strobe = 1'b0, m_err = 1'b0;
  logic [7:0] m_data = 8'h00, m_idx = 8'h00, m_status = 8'h00;
  logic [7:0] m_ctrl [0:255];

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h00)               return 8'hA5;
    else if (a == 8'h01)          return m_status;
    else if (int'(a) < NUM_REGS)  return m_ctrl[a];
    else                          return 8'hFF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] nstat;
    if (!rst_n) begin
      m_rd = 1'b0; m_wr = 1'b0; m_strobe = 1'b0; m_err = 1'b0;
      m_data = 8'h00; m_idx = 8'h00; m_status = 8'h00;
      for (int i = 0; i < 256; i++) m_ctrl[i] = 8'h00;
    end else begin
      nstat = m_status | status_set;
      m_strobe = 1'b0;
      m_err = 1'b0;
      if (m_wr) begin
        if (!wv) m_wr = 1'b0;
      end else if (m_rd) begin
        if (rack) m_rd = 1'b0;
      end else if (wv) begin
        m_wr = 1'b1;
        if (addr == 8'h01) nstat = (m_status & ~wdata) | status_set;
        else if (addr >= 8'h02 && int'(addr) < NUM_REGS) begin
          m_ctrl[addr] = wdata;
          m_strobe = 1'b1;
          m_idx = addr;
        end else m_err = 1'b1;
      end else if (re) begin
        m_rd = 1'b1;
        m_data = model_read(addr);
        m_err = (int'(addr) >= NUM_REGS);
      end
      m_status = nstat;
    end
  end

  // scoreboard compare every cycle
  always @(negedge clk) begin
    logic [CW-1:0] exp_flat;
    for (int i = 0; i < NUM_REGS - 2; i++) exp_flat[8*i +: 8] = m_ctrl[i+2];
    check("cyc_read_valid", 32'(rvalid), 32'(m_rd));
    check("cyc_write_ack", 32'(wack), 32'(m_wr));
    check("cyc_strobe", 32'(strobe), 32'(m_strobe));
    check("cyc_addr_err", 32'(addr_err), 32'(m_err));
    n_checks++;
    if (ctrl_regs !== exp_flat) begin
      n_errors++;
      $display("FAIL cyc_ctrl_regs: got 0x%0h expected 0x%0h at %0t", ctrl_regs, exp_flat, $time);
    end
    if (m_rd) check("cyc_read_data", 32'(rdata), 32'(m_data));
    if (m_strobe) check("cyc_wr_index", 32'(wr_index), 32'(m_idx));
  end

  int strobe_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (strobe === 1'b1) strobe_cnt++;
    if (addr_err === 1'b1) err_cnt++;
  end

  // driver tasks
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    int n;
    @(negedge clk);
    addr = a; wdata = d; wv = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("wr_ack_held", 32'(wack), 32'd1);
    end
    wv = 1'b0;
    n = 0;
    while (wack && n < 10) begin @(negedge clk); n++; end
    check("wr_ack_drop", 32'(wack), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input int wait_cyc, output logic [7:0] d);
    int n;
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    check("rd_latency", 32'(rvalid), 32'd1);
    n = 0;
    while (!rvalid && n < 10) begin @(negedge clk); n++; end
    d = rdata;
    re = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check("rd_valid_held", 32'(rvalid), 32'd1);
    end
    rack = 1'b1;
    @(negedge clk);
    rack = 1'b0;
    check("rd_valid_drop", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int s0, e0, n;
    repeat (3) @(negedge clk);
    check("rst_read_valid", 32'(rvalid), 32'd0);
    check("rst_write_ack", 32'(wack), 32'd0);
    check("rst_read_data", 32'(rdata), 32'd0);
    check("rst_ctrl_zero", 32'(ctrl_regs == '0), 32'd1);
    check("rst_state_idle", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // long-held write: one strobe, ack until valid drops
    s0 = strobe_cnt;
    do_write(8'h05, 8'h55, 20);
    check("wr05_strobes", 32'(strobe_cnt - s0), 32'd1);
    check("wr05_ctrl", 32'(ctrl_regs[31:24]), 32'h55);
    check("wr05_index", 32'(wr_index), 32'h05);

    do_read(8'h00, 5, d);
    check("rd_id", 32'(d), 32'hA5);

    // boundary control registers
    do_write(8'h02, 8'h11, 1);
    do_write(8'h0F, 8'hF0, 1);
    check("ctrl_first", 32'(ctrl_regs[7:0]), 32'h11);
    check("ctrl_last", 32'(ctrl_regs[CW-1 -: 8]), 32'hF0);
    do_read(8'h0F, 0, d);
    check("rd_0f", 32'(d), 32'hF0);
    e0 = err_cnt;
    do_read(8'h10, 0, d);
    check("rd_10_unmapped", 32'(d), 32'hFF);
    check("rd_10_err", 32'(err_cnt - e0), 32'd1);

    // sticky status and W1C
    @(negedge clk); status_set = 8'h81;
    @(negedge clk); status_set = 8'h00;
    do_read(8'h01, 2, d);
    check("status_81", 32'(d), 32'h81);
    do_write(8'h01, 8'h01, 2);
    do_read(8'h01, 0, d);
    check("status_w1c", 32'(d), 32'h80);
    @(negedge clk);
    addr = 8'h01; wdata = 8'h01; wv = 1'b1; status_set = 8'h01;
    @(negedge clk);
    status_set = 8'h00; wv = 1'b0;
    n = 0;
    while (wack && n < 10) begin @(negedge clk); n++; end
    do_read(8'h01, 0, d);
    check("status_set_wins", 32'(d), 32'h81);

    // unmapped and read-only accesses
    e0 = err_cnt;
    do_read(8'h20, 1, d);
    check("rd_20", 32'(d), 32'hFF);
    check("rd_20_err", 32'(err_cnt - e0), 32'd1);
    e0 = err_cnt; s0 = strobe_cnt;
    do_write(8'h20, 8'hAA, 3);
    check("wr_20_err", 32'(err_cnt - e0), 32'd1);
    check("wr_20_nostrobe", 32'(strobe_cnt - s0), 32'd0);
    e0 = err_cnt;
    do_write(8'h00, 8'h12, 2);
    check("wr_id_err", 32'(err_cnt - e0), 32'd1);
    do_read(8'h00, 0, d);
    check("id_unchanged", 32'(d), 32'hA5);

    // simultaneous read and write requests
    @(negedge clk);
    addr = 8'h03; wdata = 8'h3C; wv = 1'b1; re = 1'b1;
    repeat (3) @(negedge clk);
    check("both_wack", 32'(wack), 32'd1);
    check("both_no_rvalid", 32'(rvalid), 32'd0);
    wv = 1'b0;
    n = 0;
    while (!rvalid && n < 10) begin @(negedge clk); n++; end
    check("both_rvalid", 32'(rvalid), 32'd1);
    check("both_rdata", 32'(rdata), 32'h3C);
    re = 1'b0; rack = 1'b1;
    @(negedge clk);
    rack = 1'b0;

    // reset in the middle of a read
    @(negedge clk);
    addr = 8'h05; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_ctrl", 32'(ctrl_regs == '0), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(dbg_state), 32'd0);
    do_read(8'h05, 0, d);
    check("post_rst_ctrl05", 32'(d), 32'h00);
    do_read(8'h01, 0, d);
    check("post_rst_status", 32'(d), 32'h00);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_register_bank.md
Name: i2c_register_bank

Overview:
Register file sitting directly downstream of i2c_peripheral; consumes its register-address/read/write handshake and serves the bytes the I2C host reads and writes. Provides a read-only ID register, a sticky write-1-to-clear status register fed by hardware event inputs, and a bank of read/write control registers exported to the rest of the design. All logic runs in the system clock domain; no I2C timing knowledge lives here.

Parameters:
NUM_REGS, 16, total implemented addresses (0..NUM_REGS-1), legal range 3..256
DEVICE_ID, 8'hA5, constant returned at address 0x00
UNMAPPED_DATA, 8'hFF, byte returned for reads of addresses >= NUM_REGS

Ports:
i_sys_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_register_address  in  8  register address from i2c_peripheral
i_read_enable  in  1  read request level from peripheral
o_register_data  out  8  read data to peripheral
o_read_valid  out  1  read data valid
i_read_ack  in  1  peripheral has consumed read data
i_register_data  in  8  write data from peripheral
i_write_valid  in  1  write request level from peripheral
o_write_ack  out  1  write accepted
i_status_set  in  8  hardware event pulses, one per status bit
o_ctrl_regs  out  8*(NUM_REGS-2)  flat bus of control registers, address 2 at bits [7:0]
o_ctrl_wr_strobe  out  1  one-cycle pulse when a control register is written
o_ctrl_wr_index  out  8  address of the control register just written
o_addr_err  out  1  one-cycle pulse on any access to an unmapped or read-only-write address

Behaviour:
- Reset (async assert, sync-released use): o_register_data=0, o_read_valid=0, o_write_ack=0, status=0, all control regs=0, o_ctrl_wr_strobe=0, o_ctrl_wr_index=0, o_addr_err=0, FSM=IDLE.
- Map: 0x00 ID (RO, DEVICE_ID); 0x01 STATUS (sticky, W1C); 0x02..NUM_REGS-1 CTRL (RW); >=NUM_REGS unmapped.
- FSM states: IDLE, RD_VALID, WR_ACK.
- IDLE: i_write_valid=1 -> perform write this edge, o_write_ack<=1, go WR_ACK. Else i_read_enable=1 -> latch data for i_register_address into o_register_data, o_read_valid<=1, go RD_VALID. Write has priority when both high.
- Read latency: o_read_valid and data appear the cycle after request is seen in IDLE (1 clock). Data is a snapshot; it does not change while o_read_valid=1 even if STATUS sets.
- RD_VALID: hold o_read_valid/o_register_data until i_read_ack=1; on that edge drop o_read_valid, go IDLE. If i_read_enable still high next cycle, a new fetch of the then-current address starts (supports peripheral auto-increment bursts).
- WR_ACK: hold o_write_ack=1 until i_write_valid=0; then drop o_write_ack, go IDLE (four-phase). Exactly one register update per write handshake regardless of how long valid is held.
- Write effects: CTRL -> store byte, pulse o_ctrl_wr_strobe with o_ctrl_wr_index=address (same cycle as store visible on o_ctrl_regs). STATUS -> bits written 1 clear. ID or unmapped -> no state change, o_addr_err pulse, still acked.
- Read of unmapped address -> UNMAPPED_DATA, o_addr_err pulse, normal handshake.
- STATUS set: every cycle status |= i_status_set. Same-cycle set and W1C of one bit: set wins (bit stays 1).
- Address 8 bits compared in full; no wrap-around; NUM_REGS=256 leaves no unmapped space.
- Reset mid-handshake: FSM to IDLE, valid/ack drop immediately; a pending write is lost.

Test Plan:
- Write 0x55 to 0x05 (valid held 20 cycles) -> single o_ctrl_wr_strobe, index 0x05, o_ctrl_regs[31:24]=0x55, o_write_ack high until valid drops.
- Read 0x00 -> o_read_valid 1 clock after enable, data 0xA5, held until i_read_ack, then low.
- Pulse i_status_set=0x81, read 0x01 -> 0x81; write 0x01 to 0x01 -> read returns 0x80; repeat W1C with same-cycle set of bit0 -> bit0 stays 1.
- Read 0x20 and write 0x20 (NUM_REGS=16) -> data 0xFF, o_addr_err pulse each access, no control change; write 0x12 to 0x00 -> ID unchanged, o_addr_err.
- i_read_enable and i_write_valid rise same cycle -> write performed first, read served after write handshake completes.
- Assert i_rst_n=0 while o_read_valid=1 and control regs nonzero -> all outputs and registers 0 immediately, FSM IDLE after release.
